mem_arbiter: RTL and testbench

//   Sole owner of the byte-wide memory bus (mem_a/mem_dout/mem_din/mem_wr).

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide memory bus, serving IF word fetches and MEM loads/stores.
// Optional macro ARB_ROUND_ROBIN_EN alternates owners on simultaneous requests (default: mm priority).
module mem_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_done,
   input  logic              mm_req,
   input  logic              mm_we,
   input  logic [1:0]        mm_size,
   input  logic              mm_sext,
   input  logic [ADDR_W-1:0] mm_addr,
   input  logic [31:0]       mm_wdata,
   output logic [31:0]       mm_rdata,
   output logic              mm_done,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q;
   logic [2:0]        n_bytes;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              sext_q;
   logic              own_q;
   logic [31:0]       wdata_q;
   logic [31:0]       cap_q;
   logic              pick_mm;
   logic              gnt;
   logic              done;
   logic [1:0]        lane;
   logic [31:0]       asm_w;
   logic [31:0]       ext_w;

`ifdef ARB_ROUND_ROBIN_EN
   logic tok_q; // 1 = mm was the last owner granted
   assign pick_mm = mm_req & (~if_req | ~tok_q);
`else
   assign pick_mm = mm_req;
`endif

   assign gnt     = (state_q == IDLE) & rdy & ~rst & (if_req | mm_req);
   assign n_bytes = (size_q == 2'b00) ? 3'd1 : (size_q == 2'b01) ? 3'd2 : 3'd4;
   assign busy    = (state_q != IDLE);
   assign if_done = done & ~own_q;
   assign mm_done = done & own_q;

   // cnt_q runs one ahead of the lane being captured: byte k arrives on mem_din in cycle G+k+1
   assign lane = 2'(cnt_q - 3'd1);

   always_comb begin
      asm_w = cap_q;
      asm_w[{lane, 3'b000} +: 8] = mem_din;
      case (size_q)
         2'b00:   ext_w = {{24{sext_q & asm_w[7]}}, asm_w[7:0]};
         2'b01:   ext_w = {{16{sext_q & asm_w[15]}}, asm_w[15:0]};
         default: ext_w = asm_w;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      done     = 1'b0;
      mem_a    = '0;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
      case (state_q)
         IDLE: begin
            // byte 0 goes out in the grant cycle straight from the request inputs
            if (gnt) begin
               state_d  = (pick_mm & mm_we) ? WRITE : READ;
               mem_a    = pick_mm ? mm_addr : if_addr;
               mem_wr   = pick_mm & mm_we;
               mem_dout = (pick_mm & mm_we) ? mm_wdata[7:0] : 8'h00;
            end
         end
         WRITE: begin
            if (cnt_q < n_bytes) begin
               mem_a    = addr_q + ADDR_W'(cnt_q);
               mem_wr   = rdy;
               mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            end else begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         READ: begin
            if (cnt_q < n_bytes) begin
               mem_a = addr_q + ADDR_W'(cnt_q);
            end else if (cnt_q == n_bytes + 3'd1) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // a reset cycle must not complete the byte in flight
      if (rst) begin
         mem_a    = '0;
         mem_wr   = 1'b0;
         mem_dout = 8'h00;
         done     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 3'd0;
         addr_q   <= '0;
         size_q   <= 2'b00;
         sext_q   <= 1'b0;
         own_q    <= 1'b0;
         wdata_q  <= 32'h0;
         cap_q    <= 32'h0;
         if_rdata <= 32'h0;
         mm_rdata <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
         tok_q    <= 1'b0;
`endif
      end else if (rdy) begin
         state_q <= state_d;
         if (gnt) begin
            addr_q  <= pick_mm ? mm_addr : if_addr;
            size_q  <= pick_mm ? mm_size : 2'b10;
            sext_q  <= pick_mm & mm_sext;
            own_q   <= pick_mm;
            wdata_q <= mm_wdata;
            cnt_q   <= 3'd1;
`ifdef ARB_ROUND_ROBIN_EN
            tok_q   <= pick_mm;
`endif
         end else if (done) begin
            cnt_q <= 3'd0;
         end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + 3'd1;
         end
         if (state_q == READ && cnt_q != 3'd0 && cnt_q <= n_bytes) begin
            cap_q <= asm_w;
            if (cnt_q == n_bytes) begin
               if (own_q) mm_rdata <= ext_w;
               else       if_rdata <= ext_w;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte RAM model, reference memory and directed plus random traffic.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        if_req;
   logic [31:0] if_addr, if_rdata;
   logic        if_done;
   logic        mm_req, mm_we, mm_sext;
   logic [1:0]  mm_size;
   logic [31:0] mm_addr, mm_wdata, mm_rdata;
   logic        mm_done;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, busy;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .mm_req(mm_req), .mm_we(mm_we), .mm_size(mm_size), .mm_sext(mm_sext),
      .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mm_done(mm_done),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
   );

   int n_chk = 0, n_fail = 0, cyc = 0;
   bit rnd_on = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, got, exp, cyc);
      end
   endfunction

   function automatic void fail_now(string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endfunction

   // RAM as seen by the bus (written only by the DUT) and the reference image the model maintains
   logic [7:0] ram     [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   function automatic logic [7:0] init_byte(logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ref_rd(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   always @(posedge clk) begin
      if (rdy) begin
         mem_din <= ram.exists(mem_a) ? ram[mem_a] : init_byte(mem_a);
         if (mem_wr) ram[mem_a] = mem_dout;
      end
   end

   logic [31:0] if_q[$];
   logic [31:0] mm_q[$];
   bit          mm_st[$];
   logic [39:0] wq[$];

   function automatic int nbytes(logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] s, bit sx);
      logic [31:0] v = 32'h0;
      int n = nbytes(s);
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_rd(a + 32'(k));
      if (sx && v[8*n-1]) for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
      return v;
   endfunction

   function automatic void mm_predict(bit we, logic [1:0] s, bit sx, logic [31:0] a, logic [31:0] wd);
      if (we) begin
         for (int k = 0; k < nbytes(s); k++) begin
            wq.push_back({a + 32'(k), wd[8*k +: 8]});
            ref_mem[a + 32'(k)] = wd[8*k +: 8];
         end
         mm_q.push_back(32'h0);
         mm_st.push_back(1'b1);
      end else begin
         mm_q.push_back(model_load(a, s, sx));
         mm_st.push_back(1'b0);
      end
   endfunction

   // monitor: bus writes and done pulses against the scoreboard queues
   always @(negedge clk) begin
      if (mem_wr) begin
         if (wq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL extra bus write: got a=%h d=%h, required no write (cycle %0d)", mem_a, mem_dout, cyc);
         end else chk("bus write", 64'({mem_a, mem_dout}), 64'(wq.pop_front()));
      end
      if (rdy && if_done && mm_done) fail_now("if_done and mm_done together");
      if (rdy && if_done) begin
         if (if_q.size() == 0) fail_now("unexpected if_done");
         else chk("if_rdata", 64'(if_rdata), 64'(if_q.pop_front()));
      end
      if (rdy && mm_done) begin
         if (mm_q.size() == 0) fail_now("unexpected mm_done");
         else if (mm_st.pop_front()) void'(mm_q.pop_front());
         else chk("mm_rdata", 64'(mm_rdata), 64'(mm_q.pop_front()));
      end
   end

   task automatic wait_done(bit is_mm, output int t);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rdy && (is_mm ? mm_done : if_done)) && n < 300);
      if (n >= 300) fail_now(is_mm ? "mm_done timeout" : "if_done timeout");
      t = cyc;
      @(posedge clk); #1;
   endtask

   task automatic if_op(input logic [31:0] a, output int lat);
      int g, t;
      if_q.push_back({ref_rd(a + 32'd3), ref_rd(a + 32'd2), ref_rd(a + 32'd1), ref_rd(a)});
      if_req = 1'b1; if_addr = a; g = cyc;
      wait_done(1'b0, t);
      if_req = 1'b0; if_addr = $urandom;
      lat = t - g;
   endtask

   task automatic mm_op(input bit we, input logic [1:0] s, input bit sx, input logic [31:0] a,
                        input logic [31:0] wd, output int lat);
      int g, t;
      mm_predict(we, s, sx, a, wd);
      mm_req = 1'b1; mm_we = we; mm_size = s; mm_sext = sx; mm_addr = a; mm_wdata = wd; g = cyc;
      wait_done(1'b1, t);
      mm_req = 1'b0; mm_addr = $urandom;
      lat = t - g;
   endtask

   localparam logic [31:0] A5 = 32'h2000_0010;
   localparam logic [31:0] B6 = 32'h2000_0080;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, t, l1, l2;
      rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_addr = 32'h0;
      mm_req = 1'b0; mm_we = 1'b0; mm_size = 2'b00; mm_sext = 1'b0; mm_addr = 32'h0; mm_wdata = 32'h0;
      ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
      ram[32'h2001] = 8'h34; ram[32'h2002] = 8'h85;
      ref_mem[32'h100] = 8'h13; ref_mem[32'h101] = 8'h05; ref_mem[32'h102] = 8'h00; ref_mem[32'h103] = 8'h00;
      ref_mem[32'h2001] = 8'h34; ref_mem[32'h2002] = 8'h85;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk("reset bus outputs", 64'({mem_wr, mem_a, mem_dout, busy, if_done, mm_done}), 64'(0));
      chk("reset rdata", {if_rdata, mm_rdata}, 64'(0));
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      // word fetch: bytes at G..G+3, done at G+5
      if_q.push_back(32'h0000_0513);
      if_req = 1'b1; if_addr = 32'h100;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 4) chk("fetch issue", 64'({mem_wr, mem_a}), 64'({1'b0, 32'h100 + 32'(k)}));
         else chk("fetch done timing", 64'(if_done), 64'(k == 5));
         @(posedge clk); #1;
      end
      if_req = 1'b0;

      // byte store to the UART address: exactly one write cycle
      mm_predict(1'b1, 2'b00, 1'b0, 32'h30000, 32'h41);
      mm_req = 1'b1; mm_we = 1'b1; mm_size = 2'b00; mm_addr = 32'h30000; mm_wdata = 32'h41;
      @(negedge clk);
      chk("byte store cycle", 64'({mem_wr, mem_a, mem_dout}), 64'({1'b1, 32'h30000, 8'h41}));
      @(posedge clk); #1;
      @(negedge clk);
      chk("byte store done", 64'({mm_done, mem_wr}), 64'(2'b10));
      @(posedge clk); #1; mm_req = 1'b0;
      @(negedge clk);
      chk("idle after store", 64'({busy, mem_wr, mem_a}), 64'(0));
      @(posedge clk); #1;

      // half loads with and without sign extension
      mm_op(1'b0, 2'b01, 1'b1, 32'h2001, 32'h0, l1);
      chk("half load latency", 64'(l1), 64'(3));
      chk("half load sext", 64'(mm_rdata), 64'(32'hFFFF_8534));
      mm_op(1'b0, 2'b01, 1'b0, 32'h2001, 32'h0, l1);
      chk("half load zext", 64'(mm_rdata), 64'(32'h0000_8534));

      // simultaneous requests
      fork
         if_op(32'h200, l1);
         mm_op(1'b0, 2'b10, 1'b0, 32'h2000_0040, 32'h0, l2);
      join
`ifdef ARB_ROUND_ROBIN_EN
      chk("arb order if latency", 64'(l1), 64'(5));
      chk("arb order mm latency", 64'(l2), 64'(11));
`else
      chk("arb order mm latency", 64'(l2), 64'(5));
      chk("arb order if latency", 64'(l1), 64'(11));
`endif

      // 3-cycle pause after byte 1 of a word load
      mm_predict(1'b0, 2'b10, 1'b0, A5, 32'h0);
      mm_req = 1'b1; mm_we = 1'b0; mm_size = 2'b10; mm_sext = 1'b0; mm_addr = A5; g = cyc;
      @(posedge clk); #1; @(posedge clk); #1; rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("pause hold", 64'({mem_wr, mm_done, mem_a}), 64'({2'b00, A5 + 32'd2}));
         @(posedge clk); #1;
      end
      rdy = 1'b1;
      wait_done(1'b1, t);
      mm_req = 1'b0;
      chk("pause done delay", 64'(t - g), 64'(8));

      // reset at G+2 of a word store: only bytes 0-1 land
      wq.push_back({B6, 8'hAA}); wq.push_back({B6 + 32'd1, 8'hBB});
      ref_mem[B6] = 8'hAA; ref_mem[B6 + 32'd1] = 8'hBB;
      mm_req = 1'b1; mm_we = 1'b1; mm_size = 2'b10; mm_addr = B6; mm_wdata = 32'hDDCC_BBAA;
      @(posedge clk); #1; @(posedge clk); #1;
      rst = 1'b1; mm_req = 1'b0;
      @(negedge clk);
      chk("write blocked in reset cycle", 64'({mem_wr, mm_done}), 64'(0));
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("state after mid-access reset", 64'({mem_wr, busy, mm_done, mem_a}), 64'(0));
      @(posedge clk); #1;
      mm_op(1'b0, 2'b10, 1'b0, B6, 32'h0, l1);
      chk("word load latency", 64'(l1), 64'(5));

      // random traffic with random pauses
      rnd_on = 1'b1;
      fork
         begin
            while (rnd_on) begin
               @(posedge clk); #1;
               rdy = ($urandom_range(0, 4) != 0);
            end
            rdy = 1'b1;
         end
      join_none
      fork
         for (int i = 0; i < 40; i++) begin
            automatic int l;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if_op(32'h100 + 32'($urandom_range(0, 3839)), l);
         end
         for (int i = 0; i < 60; i++) begin
            automatic logic [31:0] a;
            automatic int l;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 7))
                                            : 32'h2000_0000 + 32'($urandom_range(0, 31));
            mm_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, l);
         end
      join
      rnd_on = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("scoreboard drained", 64'({16'(if_q.size()), 16'(mm_q.size()), 16'(wq.size())}), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
